// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with outstanding-request tracking and instruction buffer
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter int          IBUF_DEPTH = 4,
    parameter int          MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    input  logic [32:0] exception_bus,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus
);

    // Counter width covers 0..IBUF_DEPTH, which also covers 0..MAX_OUTST.
    localparam int CW  = $clog2(IBUF_DEPTH + 1);
    localparam int IPW = $clog2(IBUF_DEPTH);
    localparam int PPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] MAX_OUTST_C = CW'(MAX_OUTST);
    localparam logic [CW:0]   IBUF_CAP_C  = (CW + 1)'(IBUF_DEPTH);

    // Registered state
    logic [31:0]    req_pc_q, req_pc_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic [CW-1:0]  discard_q, discard_d;
    logic [CW-1:0]  ibuf_cnt_q, ibuf_cnt_d;
    logic [PPW-1:0] pend_wr_q, pend_wr_d;
    logic [PPW-1:0] pend_rd_q, pend_rd_d;
    logic [IPW-1:0] ibuf_head_q, ibuf_head_d;
    logic [IPW-1:0] ibuf_tail_q, ibuf_tail_d;

    // Storage arrays (contents need no reset; validity comes from the pointers/counts)
    logic [31:0] pend_pc_q [MAX_OUTST];
    logic [31:0] ibuf_inst_q [IBUF_DEPTH];
    logic [31:0] ibuf_pc_q [IBUF_DEPTH];

    // Decoded control
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] ex_pc;
    logic        redirect;
    logic [31:0] target;
    logic [CW:0] occupancy;
    logic        accept;
    logic        resp;
    logic        resp_keep;
    logic        ibuf_push;
    logic        ibuf_pop;
    logic [31:0] resp_pc;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];
    assign flush     = exception_bus[32];
    assign ex_pc     = exception_bus[31:0];

    // An exception flush outranks a branch taken in the same cycle.
    assign redirect = flush | br_taken;
    assign target   = flush ? ex_pc : br_target;

    // Live (non-discarded) in-flight responses plus buffered entries must never exceed the buffer,
    // so every response we keep is guaranteed a slot.
    assign occupancy = {1'b0, outst_q} - {1'b0, discard_q} + {1'b0, ibuf_cnt_q};

    assign inst_sram_req  = !reset && !redirect && (outst_q < MAX_OUTST_C) && (occupancy < IBUF_CAP_C);
    assign inst_sram_addr = req_pc_q;

    assign accept    = inst_sram_req && inst_sram_addr_ok;
    // A response with nothing outstanding is spurious and ignored entirely.
    assign resp      = inst_sram_data_ok && (outst_q != '0);
    assign resp_keep = resp && (discard_q == '0);
    assign resp_pc   = pend_pc_q[pend_rd_q];

    // A response arriving during a redirect is dropped along with the buffer contents.
    assign ibuf_push = resp_keep && !redirect;

    assign fs_to_ds_valid = !reset && !redirect && (ibuf_cnt_q != '0);
    assign fs_to_ds_bus   = fs_to_ds_valid ? {ibuf_inst_q[ibuf_head_q], ibuf_pc_q[ibuf_head_q]} : 64'd0;
    assign ibuf_pop       = fs_to_ds_valid && ds_allowin;

    // Pending-PC FIFO pointer advance; depth need not be a power of two.
    function automatic logic [PPW-1:0] pend_next(input logic [PPW-1:0] p);
        if (p == PPW'(MAX_OUTST - 1)) begin
            return '0;
        end
        return p + PPW'(1);
    endfunction

    // Next fetch address: redirect target wins, otherwise advance on each accepted request.
    always_comb begin
        req_pc_d = req_pc_q;
        if (redirect) begin
            req_pc_d = target;
        end else if (accept) begin
            req_pc_d = req_pc_q + 32'd4;
        end
    end

    // Outstanding and discard counters; a redirect marks every still-unreturned response as stale.
    always_comb begin
        outst_d   = outst_q;
        discard_d = discard_q;
        case ({accept, resp})
            2'b10:   outst_d = outst_q + CNT_ONE;
            2'b01:   outst_d = outst_q - CNT_ONE;
            default: outst_d = outst_q;
        endcase
        if (redirect) begin
            // No request is accepted in a redirect cycle, so what remains outstanding is all stale.
            discard_d = outst_q - (resp ? CNT_ONE : '0);
        end else if (resp && (discard_q != '0)) begin
            discard_d = discard_q - CNT_ONE;
        end
    end

    // Pending-PC FIFO pointers: push on accept, pop on every counted response.
    always_comb begin
        pend_wr_d = pend_wr_q;
        pend_rd_d = pend_rd_q;
        if (accept) begin
            pend_wr_d = pend_next(pend_wr_q);
        end
        if (resp) begin
            pend_rd_d = pend_next(pend_rd_q);
        end
    end

    // Instruction buffer pointers and count; a redirect empties it outright.
    always_comb begin
        ibuf_head_d = ibuf_head_q;
        ibuf_tail_d = ibuf_tail_q;
        ibuf_cnt_d  = ibuf_cnt_q;
        if (redirect) begin
            ibuf_head_d = '0;
            ibuf_tail_d = '0;
            ibuf_cnt_d  = '0;
        end else begin
            if (ibuf_push) begin
                ibuf_tail_d = ibuf_tail_q + IPW'(1);
            end
            if (ibuf_pop) begin
                ibuf_head_d = ibuf_head_q + IPW'(1);
            end
            case ({ibuf_push, ibuf_pop})
                2'b10:   ibuf_cnt_d = ibuf_cnt_q + CNT_ONE;
                2'b01:   ibuf_cnt_d = ibuf_cnt_q - CNT_ONE;
                default: ibuf_cnt_d = ibuf_cnt_q;
            endcase
        end
    end

    // State register; reset abandons all in-flight requests and empties both FIFOs.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_pc_q    <= RESET_PC;
            outst_q     <= '0;
            discard_q   <= '0;
            pend_wr_q   <= '0;
            pend_rd_q   <= '0;
            ibuf_head_q <= '0;
            ibuf_tail_q <= '0;
            ibuf_cnt_q  <= '0;
        end else begin
            req_pc_q    <= req_pc_d;
            outst_q     <= outst_d;
            discard_q   <= discard_d;
            pend_wr_q   <= pend_wr_d;
            pend_rd_q   <= pend_rd_d;
            ibuf_head_q <= ibuf_head_d;
            ibuf_tail_q <= ibuf_tail_d;
            ibuf_cnt_q  <= ibuf_cnt_d;
        end
    end

    // FIFO data storage: record the PC of each accepted request and each kept response.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_pc_q[pend_wr_q] <= req_pc_q;
        end
        if (ibuf_push && !reset) begin
            ibuf_inst_q[ibuf_tail_q] <= inst_sram_rdata;
            ibuf_pc_q[ibuf_tail_q]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic [32:0] exception_bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .exception_bus     (exception_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];

    // Per-cycle stimulus controls, applied by step() at the falling edge
    logic        c_reset   = 1'b1;
    logic        c_allow   = 1'b0;
    logic        c_bt      = 1'b0;
    logic [31:0] c_btgt    = 32'h0;
    logic        c_fl      = 1'b0;
    logic [31:0] c_epc     = 32'h0;
    logic        c_resp_en = 1'b1;
    logic        c_aok     = 1'b1;
    logic        c_spur    = 1'b0;

    // Outputs sampled mid-cycle by step()
    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, sample outputs, update the memory model at posedge.
    task automatic step();
        logic acc;
        logic dok;
        @(negedge clk);
        reset             = c_reset;
        ds_allowin        = c_allow;
        br_bus            = {c_bt, c_btgt};
        exception_bus     = {c_fl, c_epc};
        inst_sram_addr_ok = c_aok;
        if (c_spur) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = 32'hdeadbeef;
        end else if (!c_reset && c_resp_en && mem_q.size() > 0) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = inst_of(mem_q[0]);
        end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = 32'h0;
        end
        #1;
        s_req   = inst_sram_req;
        s_addr  = inst_sram_addr;
        s_valid = fs_to_ds_valid;
        acc     = s_req && c_aok;
        dok     = inst_sram_data_ok && !c_spur;
        @(posedge clk);
        if (c_reset) begin
            mem_q.delete();
        end else begin
            if (dok) void'(mem_q.pop_front());
            if (acc) mem_q.push_back(s_addr);
        end
    endtask

    task automatic do_reset();
        c_reset = 1'b1; c_allow = 1'b0; c_bt = 1'b0; c_fl = 1'b0;
        c_spur = 1'b0; c_resp_en = 1'b1; c_aok = 1'b1;
        step();
        check1("reset_req", s_req, 1'b0);
        check1("reset_valid", s_valid, 1'b0);
        step();
        c_reset = 1'b0;
    endtask

    task automatic check_drained(input string name);
        c_allow = 1'b0;
        step();
        check32(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every handshake to decode pops the scoreboard and compares.
    initial begin
        forever begin
            logic [31:0] e;
            @(negedge clk);
            #2;
            if (fs_to_ds_valid === 1'b1 && ds_allowin === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got pc %h, none expected", fs_to_ds_bus[31:0]);
                end else begin
                    e = exp_q.pop_front();
                    check32("deliver_pc", fs_to_ds_bus[31:0], e);
                    check32("deliver_inst", fs_to_ds_bus[63:32], inst_of(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ds_allowin = 1'b0; br_bus = '0; exception_bus = '0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;

        // Streaming after reset; a spurious data_ok with nothing outstanding is ignored
        do_reset();
        exp_q.push_back(32'hbfc00000); exp_q.push_back(32'hbfc00004); exp_q.push_back(32'hbfc00008);
        c_allow = 1'b1; c_spur = 1'b1;
        step();
        check1("a_first_req", s_req, 1'b1);
        check32("a_first_addr", s_addr, 32'hbfc00000);
        c_spur = 1'b0;
        step();
        check1("a_c1_valid", s_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check1("a_valid_consec", s_valid, 1'b1);
        end
        check_drained("a_sb_empty");

        // Decode stalled: buffer fills to 4, request held low, then 4 back-to-back
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 5) check1("b_req_held_low", s_req, 1'b0);
        end
        check1("b_valid_stalled", s_valid, 1'b1);
        exp_q.push_back(32'hbfc00000); exp_q.push_back(32'hbfc00004);
        exp_q.push_back(32'hbfc00008); exp_q.push_back(32'hbfc0000c);
        c_allow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check1("b_valid_b2b", s_valid, 1'b1);
        end
        check_drained("b_sb_empty");

        // Branch with 2 outstanding: both responses dropped, next pc 0x1000
        do_reset();
        c_allow = 1'b1; c_resp_en = 1'b0;
        step();
        step();
        c_bt = 1'b1; c_btgt = 32'h00001000;
        step();
        check1("c_req_in_redirect", s_req, 1'b0);
        c_bt = 1'b0; c_resp_en = 1'b1;
        exp_q.push_back(32'h00001000); exp_q.push_back(32'h00001004);
        step();
        check1("c_req_while_discarding", s_req, 1'b0);
        check32("c_addr_redirected", s_addr, 32'h00001000);
        step();
        check1("c_first_req", s_req, 1'b1);
        check32("c_first_addr", s_addr, 32'h00001000);
        step(); step(); step();
        check_drained("c_sb_empty");

        // Flush and branch together: flush target wins; data_ok in redirect cycle dropped
        do_reset();
        step();
        step();
        c_fl = 1'b1; c_epc = 32'hbfc00380; c_bt = 1'b1; c_btgt = 32'h00002000;
        step();
        check1("d_req_in_redirect", s_req, 1'b0);
        check1("d_valid_in_redirect", s_valid, 1'b0);
        c_fl = 1'b0; c_bt = 1'b0; c_allow = 1'b1;
        exp_q.push_back(32'hbfc00380); exp_q.push_back(32'hbfc00384);
        step();
        check1("d_first_req", s_req, 1'b1);
        check32("d_first_addr", s_addr, 32'hbfc00380);
        step(); step(); step();
        check_drained("d_sb_empty");

        // Branch while streaming, with coincident data_ok and 1 outstanding
        do_reset();
        c_allow = 1'b1;
        exp_q.push_back(32'hbfc00000);
        step(); step(); step();
        c_bt = 1'b1; c_btgt = 32'h00004000;
        step();
        check1("e_valid_in_redirect", s_valid, 1'b0);
        c_bt = 1'b0;
        exp_q.push_back(32'h00004000); exp_q.push_back(32'h00004004);
        step();
        check32("e_first_addr", s_addr, 32'h00004000);
        step(); step(); step();
        check_drained("e_sb_empty");

        // Reset mid-operation with 2 outstanding and 2 buffered
        do_reset();
        step(); step(); step();
        c_resp_en = 1'b0;
        step();
        step();
        check1("f_req_outst_full", s_req, 1'b0);
        check1("f_valid_buffered", s_valid, 1'b1);
        c_reset = 1'b1;
        step();
        check1("f_req_in_reset", s_req, 1'b0);
        check1("f_valid_in_reset", s_valid, 1'b0);
        c_reset = 1'b0; c_resp_en = 1'b1; c_allow = 1'b1;
        exp_q.push_back(32'hbfc00000); exp_q.push_back(32'hbfc00004);
        step();
        check1("f_restart_req", s_req, 1'b1);
        check32("f_restart_addr", s_addr, 32'hbfc00000);
        step(); step(); step();
        check_drained("f_sb_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
